// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types, constants and helpers for the binary-to-BCD
// display feed.
//   bin2bcd_state_t : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_NIBBLE_W    : bits per BCD digit
//   bcd_all_nines() : saturated all-9s word, low 'digits' nibbles populated
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bin2bcd_state_t;

  localparam int BCD_NIBBLE_W = 4;
  localparam int MAX_DIGITS   = 16;
  localparam int MAX_BCD_W    = MAX_DIGITS * BCD_NIBBLE_W;

  // Caller truncates the result to its own 4*DIGITS width.
  function automatic logic [MAX_BCD_W-1:0] bcd_all_nines(input int digits);
    logic [MAX_BCD_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) w[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] = 4'd9;
    end
    return w;
  endfunction

endpackage

// File: rtl/bin2bcd_display_feed_add3.sv
// bcd_add3_nibble: combinational double-dabble correction cell.
// Adds 3 to a BCD nibble that is 5 or more so the following left shift
// carries correctly into the next decimal digit. Pure 4-bit arithmetic:
// valid inputs (0..9) never need a carry out (9 -> 12).
//   nib_i : scratch nibble before correction
//   nib_o : corrected nibble
module bcd_add3_nibble (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin2bcd_display_feed.sv
// bin2bcd_display_feed: sequential shift-and-add-3 binary-to-BCD converter
// between the CPU output port register and the seven-segment driver.
// One shift per clock; a conversion takes W+2 cycles from accept to the
// next accept.
// Optional feature macro: BIN2BCD_LEADING_ZERO_BLANK_EN (leading-zero blank
// requests on digit_blank; when undefined digit_blank is tied low).
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   bin_in      : binary value to convert (W bits)
//   in_valid    : bin_in valid; accepted when in_valid & in_ready
//   in_ready    : converter idle and able to accept
//   bcd_out     : packed BCD result, digit 0 in [3:0]; holds last result
//   out_valid   : one-cycle pulse when bcd_out/overflow were updated
//   overflow    : last result exceeded 10^DIGITS-1 and was saturated
//   digit_blank : per-digit leading-zero blank request
module bin2bcd_display_feed
  import bin2bcd_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [W-1:0]                   bin_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DIGITS*BCD_NIBBLE_W-1:0] bcd_out,
  output logic                           out_valid,
  output logic                           overflow,
  output logic [DIGITS-1:0]              digit_blank
);

  localparam int BCD_W = DIGITS * BCD_NIBBLE_W;
  // One spare digit above the displayed ones catches values >= 10^DIGITS.
  localparam int SCR_W = (DIGITS + 1) * BCD_NIBBLE_W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [BCD_W-1:0] NINES = BCD_W'(bcd_all_nines(DIGITS));

  bin2bcd_state_t    state_q, state_d;
  logic [W-1:0]      bin_q, bin_d;
  logic [SCR_W-1:0]  scr_q, scr_d;
  logic [SCR_W-1:0]  scr_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              vld_q, vld_d;
  logic              res_ovf;

  for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .nib_i (scr_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .nib_o (scr_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Saturate when the spare top digit is used or a displayed digit is
  // not a legal BCD value.
  always_comb begin
    res_ovf = (scr_q[SCR_W-1 -: BCD_NIBBLE_W] != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] > 4'd9) res_ovf = 1'b1;
    end
  end

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_res;
  logic              zero_above;

  // Digit i is blanked when it and every higher digit are zero; digit 0
  // always shows so a zero result reads "0".
  always_comb begin
    blank_res  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above   = zero_above & (scr_q[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] == '0);
      blank_res[i] = zero_above;
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = '0;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    blank_d = blank_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Correct all nibbles first, then shift the binary MSB into scratch.
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
      end
      DONE: begin
        vld_d = 1'b1;
        if (res_ovf) begin
          bcd_d = NINES;
          ovf_d = 1'b1;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
          blank_d = '0;
`endif
        end else begin
          bcd_d = scr_q[BCD_W-1:0];
          ovf_d = 1'b0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
          blank_d = blank_res;
`endif
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_bin2bcd_display_feed.sv
// Self-checking bench for bin2bcd_display_feed (W=16, DIGITS=4).
module tb_bin2bcd_display_feed;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bin_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic        out_valid;
  logic        overflow;
  logic [3:0]  digit_blank;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          edge_n;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } res_t;
  res_t ov_q[$];

  typedef struct {
    logic [15:0] v;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } vec_t;
  vec_t tbl[10];

  bin2bcd_display_feed #(.W(16), .DIGITS(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bin_in      (bin_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bcd_out     (bcd_out),
    .out_valid   (out_valid),
    .overflow    (overflow),
    .digit_blank (digit_blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every out_valid pulse with the number of the edge that raised it.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) ov_q.push_back('{cyc, bcd_out, overflow, digit_blank});
  end

  // Reference model: decimal digits of the saturated value.
  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    logic [3:0] b;
    b = '0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    if (v <= 9999) begin
      b[1] = (v < 10);
      b[2] = (v < 100);
      b[3] = (v < 1000);
    end
`endif
    return b;
  endfunction

  function automatic logic [3:0] tbl_blank(input logic [3:0] b);
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    return b;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns the edge number at which bin_in is accepted.
  task automatic accept(input logic [15:0] v, output int n);
    int t;
    bin_in = v;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    n = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_edge, input logic [15:0] e_bcd,
                             input logic e_ovf, input logic [3:0] e_blank);
    int t;
    res_t r;
    t = 0;
    while (ov_q.size() == 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (ov_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual=no out_valid required=out_valid by edge %0d", name, exp_edge);
    end else begin
      r = ov_q.pop_front();
      if (exp_edge >= 0) chk({name, "_edge"}, r.edge_n, exp_edge);
      chk({name, "_bcd"}, {16'd0, r.bcd}, {16'd0, e_bcd});
      chk({name, "_ovf"}, {31'd0, r.ovf}, {31'd0, e_ovf});
      chk({name, "_blank"}, {28'd0, r.blank}, {28'd0, e_blank});
    end
  endtask

  task automatic run_one(input string name, input logic [15:0] v, input logic [15:0] e_bcd,
                         input logic e_ovf, input logic [3:0] e_blank);
    int n;
    accept(v, n);
    wait_result(name, n + 17, e_bcd, e_ovf, e_blank);
    repeat (3) @(negedge clk);
    chk({name, "_single_pulse"}, ov_q.size(), 0);
  endtask

  initial begin
    int n;
    int cnt_ready;
    int sent;
    int got;
    int prev_edge;
    int budget;
    logic [15:0] v;
    logic [15:0] exp_v[$];
    res_t r;

    tbl[0] = '{16'd1234,  16'h1234, 1'b0, 4'b0000};
    tbl[1] = '{16'd0,     16'h0000, 1'b0, 4'b1110};
    tbl[2] = '{16'd9999,  16'h9999, 1'b0, 4'b0000};
    tbl[3] = '{16'd10000, 16'h9999, 1'b1, 4'b0000};
    tbl[4] = '{16'd65535, 16'h9999, 1'b1, 4'b0000};
    tbl[5] = '{16'd7,     16'h0007, 1'b0, 4'b1110};
    tbl[6] = '{16'd100,   16'h0100, 1'b0, 4'b1000};
    tbl[7] = '{16'd1000,  16'h1000, 1'b0, 4'b0000};
    tbl[8] = '{16'd10,    16'h0010, 1'b0, 4'b1100};
    tbl[9] = '{16'd5005,  16'h5005, 1'b0, 4'b0000};

    // Reset held for three cycles, then idle outputs.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_bcd", {16'd0, bcd_out}, 32'd0);
    chk("idle_ovf", {31'd0, overflow}, 32'd0);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_blank", {28'd0, digit_blank}, 32'd0);

    // Directed vectors including boundaries.
    for (int i = 0; i < 10; i++) begin
      run_one($sformatf("vec%0d", i), tbl[i].v, tbl[i].bcd, tbl[i].ovf, tbl_blank(tbl[i].blank));
      chk($sformatf("vec%0d_hold_bcd", i), {16'd0, bcd_out}, {16'd0, tbl[i].bcd});
    end

    // Busy rejection: 99 presented while converting 42, then held.
    accept(16'd42, n);
    bin_in = 16'd99;
    in_valid = 1'b1;
    cnt_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) cnt_ready++;
      @(negedge clk);
    end
    chk("busy_in_ready_low", cnt_ready, 0);
    wait_result("busy_first", n + 17, 16'h0042, 1'b0, tbl_blank(4'b1100));
    budget = 0;
    while (in_ready !== 1'b1 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    chk("busy_rearm_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("busy_second", n + 35, 16'h0099, 1'b0, tbl_blank(4'b1100));
    repeat (3) @(negedge clk);
    chk("busy_pulse_count", ov_q.size(), 0);

    // Reset in the middle of a conversion.
    accept(16'd5555, n);
    while (cyc < n + 7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_bcd", {16'd0, bcd_out}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    chk("midrst_blank", {28'd0, digit_blank}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    while (cyc < n + 20) @(negedge clk);
    chk("midrst_no_pulse", ov_q.size(), 0);
    run_one("after_rst", 16'd321, 16'h0321, 1'b0, tbl_blank(4'b1000));

    // Back-to-back random values with in_valid held high.
    sent = 0;
    got = 0;
    prev_edge = -1;
    budget = 0;
    while (got < 200 && budget < 6000) begin
      @(negedge clk);
      budget++;
      while (ov_q.size() > 0) begin
        r = ov_q.pop_front();
        v = exp_v.pop_front();
        chk($sformatf("rnd%0d_bcd(v=%0d)", got, v), {16'd0, r.bcd}, {16'd0, ref_bcd(int'(v))});
        chk($sformatf("rnd%0d_ovf", got), {31'd0, r.ovf}, {31'd0, (v > 16'd9999)});
        chk($sformatf("rnd%0d_blank", got), {28'd0, r.blank}, {28'd0, ref_blank(int'(v))});
        if (prev_edge >= 0) chk($sformatf("rnd%0d_spacing", got), r.edge_n - prev_edge, 18);
        prev_edge = r.edge_n;
        got++;
      end
      if (in_ready === 1'b1 && sent < 200) begin
        if (sent % 8 == 3) v = 16'($urandom_range(9985, 10015));
        else if (sent % 8 == 5) v = 16'($urandom_range(0, 120));
        else v = 16'($urandom);
        bin_in = v;
        in_valid = 1'b1;
        exp_v.push_back(v);
        sent++;
      end else if (sent >= 200 && in_ready === 1'b1) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("rnd_result_count", got, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
